// File: rtl/convolve_mem_pkg.sv
// Shared constants for the convolve scratch-memory arbiter: widths, requester
// indices, FSM state type and the rotation helper.
package convolve_mem_pkg;

  localparam int MEM_ADDR_W = 12;
  localparam int MEM_DATA_W = 32;
  localparam int OWNER_W    = 3;
  localparam int HOLD_W     = 16;

  localparam int REQ_CONVOLVE = 0;
  localparam int REQ_LAGWIN   = 1;
  localparam int REQ_AUTOCORR = 2;
  localparam int REQ_TEST     = 3;
  localparam int NUM_ENGINES  = REQ_TEST + 1;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_e;

  // Next requester index after idx, wrapping at n.
  function automatic logic [OWNER_W-1:0] wrap_inc(input logic [OWNER_W-1:0] idx,
                                                  input int n);
    if (int'(idx) >= n - 1) return '0;
    return idx + OWNER_W'(1);
  endfunction

endpackage

// File: rtl/convolve_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request scanning from start_i
// upward, modulo NUM_REQ.
module rr_pick
  import convolve_mem_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [OWNER_W-1:0] start_i,
  output logic [OWNER_W-1:0] win_idx_o,
  output logic               win_valid_o
);

  logic [NUM_REQ-1:0] rot;

  // Rotate so that bit 0 is the requester at start_i.
  assign rot = NUM_REQ'({req_i, req_i} >> start_i);

  always_comb begin
    win_idx_o   = '0;
    win_valid_o = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        win_valid_o = 1'b1;
        if (int'(start_i) + k >= NUM_REQ) win_idx_o = OWNER_W'(int'(start_i) + k - NUM_REQ);
        else                              win_idx_o = OWNER_W'(int'(start_i) + k);
      end
    end
  end

endmodule

// File: rtl/convolve_mem_arbiter.sv
// Round-robin, burst-locking arbiter for the convolve scratch memory port.
// A granted engine keeps the port until it drops req; handoff has no bubble.
module convolve_mem_arbiter
  import convolve_mem_pkg::*;
#(
  parameter int NUM_REQ  = NUM_ENGINES,
  parameter int ADDR_W   = MEM_ADDR_W,
  parameter int DATA_W   = MEM_DATA_W,
  parameter int MAX_HOLD = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        reqWriteEn,
  input  logic [NUM_REQ*ADDR_W-1:0] reqWriteAddr,
  input  logic [NUM_REQ*ADDR_W-1:0] reqReadAddr,
  input  logic [NUM_REQ*DATA_W-1:0] reqWriteData,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      memWriteEn,
  output logic [ADDR_W-1:0]         memWriteAddr,
  output logic [ADDR_W-1:0]         memReadAddr,
  output logic [DATA_W-1:0]         memOut,
  output logic                      busy,
  output logic [OWNER_W-1:0]        owner,
  output logic                      holdTimeout
);

  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_SAT   = '1;
  localparam bit                HOLD_EN    = (MAX_HOLD != 0);

  arb_state_e           state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [OWNER_W-1:0]   owner_q, owner_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic                 timeout_q, timeout_d;

  logic [OWNER_W-1:0]   start_idx;
  logic [OWNER_W-1:0]   pick_idx;
  logic                 pick_valid;
  logic                 owner_req;

  // The same rotation start serves both the idle grant and the handoff.
  assign start_idx = wrap_inc(owner_q, NUM_REQ);
  assign owner_req = |(req & grant_q);

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req_i       (req),
    .start_i     (start_idx),
    .win_idx_o   (pick_idx),
    .win_valid_o (pick_valid)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    hold_d    = hold_q;
    timeout_d = timeout_q;
    grant_d   = '0;
    case (state_q)
      ARB_IDLE: begin
        hold_d = '0;
        if (pick_valid) begin
          state_d = ARB_OWNED;
          owner_d = pick_idx;
        end
      end
      ARB_OWNED: begin
        if (owner_req) begin
          hold_d = (hold_q == HOLD_SAT) ? hold_q : hold_q + HOLD_W'(1);
        end else begin
          hold_d = '0;
          if (pick_valid) owner_d = pick_idx;
          else            state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_d[i] = (state_d == ARB_OWNED) && (owner_d == OWNER_W'(i));
    end
    if (HOLD_EN && (state_d == ARB_OWNED) && (hold_d == HOLD_LIMIT)) timeout_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ARB_IDLE;
      grant_q   <= '0;
      owner_q   <= OWNER_W'(NUM_REQ - 1);
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  // AND-OR mux on the one-hot grant: everything reads zero while idle.
  logic [ADDR_W-1:0] wa_m [NUM_REQ];
  logic [ADDR_W-1:0] ra_m [NUM_REQ];
  logic [DATA_W-1:0] wd_m [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign wa_m[gi] = grant_q[gi] ? reqWriteAddr[gi*ADDR_W +: ADDR_W] : '0;
    assign ra_m[gi] = grant_q[gi] ? reqReadAddr[gi*ADDR_W +: ADDR_W]  : '0;
    assign wd_m[gi] = grant_q[gi] ? reqWriteData[gi*DATA_W +: DATA_W] : '0;
  end

  always_comb begin
    memWriteAddr = '0;
    memReadAddr  = '0;
    memOut       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      memWriteAddr = memWriteAddr | wa_m[i];
      memReadAddr  = memReadAddr  | ra_m[i];
      memOut       = memOut       | wd_m[i];
    end
  end

  assign busy        = (state_q == ARB_OWNED);
  assign grant       = grant_q;
  assign owner       = owner_q;
  assign holdTimeout = timeout_q;
  assign memWriteEn  = busy & |(reqWriteEn & grant_q);

endmodule

// File: tb/tb_convolve_mem_arbiter.sv
// Scoreboard bench for convolve_mem_arbiter: directed scenarios then random
// traffic, checked every cycle against a queue-fed reference model.
module tb_convolve_mem_arbiter;
  import convolve_mem_pkg::*;

  localparam int NR = 4;
  localparam int AW = 12;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [NR-1:0]   req = '0;
  logic [NR-1:0]   wen = '0;
  logic [NR*AW-1:0] wa = '0;
  logic [NR*AW-1:0] ra = '0;
  logic [NR*DW-1:0] wd = '0;

  logic [NR-1:0]   grant_a, grant_b;
  logic            we_a, we_b, busy_a, busy_b, to_a, to_b;
  logic [AW-1:0]   wa_a, wa_b, ra_a, ra_b;
  logic [DW-1:0]   wd_a, wd_b;
  logic [2:0]      own_a, own_b;

  always #5 clk = ~clk;

  convolve_mem_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(8)) dut (
    .clk(clk), .reset(reset), .req(req), .reqWriteEn(wen), .reqWriteAddr(wa),
    .reqReadAddr(ra), .reqWriteData(wd), .grant(grant_a), .memWriteEn(we_a),
    .memWriteAddr(wa_a), .memReadAddr(ra_a), .memOut(wd_a), .busy(busy_a),
    .owner(own_a), .holdTimeout(to_a));

  convolve_mem_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(0)) dut0 (
    .clk(clk), .reset(reset), .req(req), .reqWriteEn(wen), .reqWriteAddr(wa),
    .reqReadAddr(ra), .reqWriteData(wd), .grant(grant_b), .memWriteEn(we_b),
    .memWriteAddr(wa_b), .memReadAddr(ra_b), .memOut(wd_b), .busy(busy_b),
    .owner(own_b), .holdTimeout(to_b));

  typedef struct {
    logic [NR-1:0] grant;
    logic          busy;
    logic [2:0]    owner;
    logic          to;
    logic          we;
    logic [AW-1:0] wa;
    logic [AW-1:0] ra;
    logic [DW-1:0] wd;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  bit   force_fff = 1'b0;

  // Reference model: who owns the port, how long, and the sticky flag.
  logic [1:0] m_owner = 2'd3;
  bit         m_granted = 1'b0;
  int         m_hold = 0;
  bit         m_to = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req_v, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = 2'd3; m_granted = 1'b0; m_hold = 0; m_to = 1'b0;
  endtask

  // Clock edge as seen by the arbiter: r is the request vector at that edge.
  task automatic model_edge(input logic [NR-1:0] r);
    bit         found;
    logic [1:0] c;
    logic [1:0] w;
    if (!reset) begin
      model_reset();
      return;
    end
    if (m_granted && r[m_owner]) begin
      if (m_hold < 65535) m_hold++;
    end else begin
      found = 1'b0;
      w = 2'd0;
      for (int k = 1; k <= NR; k++) begin
        c = m_owner + 2'(k);
        if (!found && r[c]) begin found = 1'b1; w = c; end
      end
      m_granted = found;
      m_hold = 0;
      if (found) m_owner = w;
    end
    if (m_granted && m_hold == 8) m_to = 1'b1;
  endtask

  task automatic push_expected();
    exp_t e;
    e.grant = m_granted ? (NR'(1) << m_owner) : '0;
    e.busy  = m_granted;
    e.owner = {1'b0, m_owner};
    e.to    = m_to;
    e.we    = m_granted ? wen[m_owner] : 1'b0;
    e.wa    = m_granted ? wa[m_owner*AW +: AW] : '0;
    e.ra    = m_granted ? ra[m_owner*AW +: AW] : '0;
    e.wd    = m_granted ? wd[m_owner*DW +: DW] : '0;
    exp_q.push_back(e);
  endtask

  task automatic randomize_ports();
    wen = NR'($urandom);
    for (int i = 0; i < NR; i++) begin
      wa[i*AW +: AW] = AW'($urandom);
      ra[i*AW +: AW] = AW'($urandom);
      wd[i*DW +: DW] = $urandom;
    end
    if (force_fff) begin
      wen[3] = 1'b1;
      wa[3*AW +: AW] = 12'hFFF;
    end
  endtask

  // One cycle: edge, then new inputs 2ns later, then the expected view pushed.
  task automatic drive_rst(input logic rst_v, input logic [NR-1:0] r);
    @(posedge clk);
    model_edge(req);
    #2;
    reset = rst_v;
    req = r;
    randomize_ports();
    if (!rst_v) begin
      model_reset();
      #1;
      chk("async_reset_grant", 64'(grant_a), 64'(0));
      chk("async_reset_busy", 64'(busy_a), 64'(0));
    end
    push_expected();
  endtask

  task automatic drive(input logic [NR-1:0] r);
    drive_rst(1'b1, r);
  endtask

  task automatic drive_n(input logic [NR-1:0] r, input int n);
    for (int i = 0; i < n; i++) drive(r);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("grant", 64'(grant_a), 64'(e.grant));
      chk("busy", 64'(busy_a), 64'(e.busy));
      chk("owner", 64'(own_a), 64'(e.owner));
      chk("hold_timeout", 64'(to_a), 64'(e.to));
      chk("mem_write_en", 64'(we_a), 64'(e.we));
      chk("mem_write_addr", 64'(wa_a), 64'(e.wa));
      chk("mem_read_addr", 64'(ra_a), 64'(e.ra));
      chk("mem_out", 64'(wd_a), 64'(e.wd));
      chk("timeout_disabled", 64'(to_b), 64'(0));
      chk("grant_maxhold0", 64'(grant_b), 64'(e.grant));
    end
  end

  initial begin
    logic [NR-1:0] r;
    // Reset held, then released.
    drive_rst(1'b0, 4'b0000);
    drive_rst(1'b0, 4'b0000);
    drive(4'b0000);
    // Single requester.
    drive_n(4'b0001, 4);
    drive_n(4'b0000, 2);
    // Rotation: 2-cycle bursts, owner drops for one cycle.
    drive(4'b1111);
    for (int n = 0; n < 5; n++) begin
      drive(4'b1111);
      drive(4'b1111 & ~(NR'(1) << m_owner));
    end
    drive_n(4'b0000, 2);
    // Burst lock with a competing request, then zero-bubble handoff.
    drive_n(4'b0010, 2);
    drive_n(4'b0110, 4);
    drive_n(4'b0100, 2);
    drive_n(4'b0000, 2);
    // Non-owner writes from requester 3 at 12'hFFF must not reach the port.
    force_fff = 1'b1;
    drive_n(4'b0001, 5);
    force_fff = 1'b0;
    drive_n(4'b0000, 3);
    // Long hold on requester 2 trips the timeout, which stays set.
    drive_n(4'b0100, 20);
    drive_n(4'b0000, 3);
    // Reset in the middle of a burst, released with two requests pending.
    drive_n(4'b0100, 3);
    drive_rst(1'b0, 4'b0101);
    drive_n(4'b0101, 3);
    drive_n(4'b0000, 2);
    // Random bursty traffic.
    r = '0;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NR; i++) begin
        if ($urandom_range(0, 4) == 0) r[i] = ~r[i];
      end
      if (n == 200) drive_rst(1'b0, r);
      else          drive(r);
    end
    drive_n(4'b0000, 3);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
